adc_wave_meter: RTL and testbench



---
 rtl/adc_wave_meter.sv | 150 +++++++++++++++
 tb/tb_adc_wave_meter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/adc_wave_meter.sv
`default_nettype none
// ============================================================================
// adc_wave_meter : ADC sample-clock driver with windowed frequency/amplitude meter
// Revision 1.0
// ============================================================================
module adc_wave_meter #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned GATE_CYC = 50_000_000,
  parameter int unsigned HYST     = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  ad_data,
  output logic        ad_clk,
  output logic [31:0] freq,
  output logic [7:0]  vmax,
  output logic [7:0]  vmin,
  output logic [7:0]  vpp,
  output logic        meas_valid
);

  typedef enum logic [0:0] {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  localparam logic [31:0] C_DIV_LAST  = 32'(CLK_DIV - 1);
  localparam logic [31:0] C_GATE_LAST = 32'(GATE_CYC - 1);
  localparam logic [8:0]  C_HYST      = 9'(HYST);

  logic [31:0] div_cnt_q, div_cnt_d;
  logic        ad_clk_q, ad_clk_d;
  logic [7:0]  smp_q, smp_d;
  logic        smp_v_q, smp_v_d;
  logic [31:0] gate_cnt_q, gate_cnt_d;
  logic [7:0]  cur_max_q, cur_max_d;
  logic [7:0]  cur_min_q, cur_min_d;
  logic [31:0] edge_cnt_q, edge_cnt_d;
  state_t      state_q, state_d;
  logic [7:0]  mid_q, mid_d;
  logic [31:0] freq_q, freq_d;
  logic [7:0]  vmax_q, vmax_d;
  logic [7:0]  vmin_q, vmin_d;
  logic [7:0]  vpp_q, vpp_d;
  logic        meas_valid_q, meas_valid_d;

  logic        div_wrap, sample_en, gate_end, rise, fall;
  logic [8:0]  hi_sum, lo_diff, mid_sum;
  logic [7:0]  hi_th, lo_th, max_fold, min_fold;
  logic [31:0] edge_fold;

  always_comb begin
    div_wrap  = (div_cnt_q == C_DIV_LAST);
    sample_en = div_wrap && ad_clk_q;
    div_cnt_d = div_wrap ? 32'd0 : div_cnt_q + 32'd1;
    ad_clk_d  = ad_clk_q ^ div_wrap;
    smp_v_d   = sample_en;
    smp_d     = sample_en ? ad_data : smp_q;

    gate_end   = (gate_cnt_q == C_GATE_LAST);
    gate_cnt_d = gate_end ? 32'd0 : gate_cnt_q + 32'd1;

    // Thresholds are clamped through the 9th bit (carry above, borrow below).
    hi_sum  = {1'b0, mid_q} + C_HYST;
    lo_diff = {1'b0, mid_q} - C_HYST;
    hi_th   = hi_sum[8]  ? 8'hFF : hi_sum[7:0];
    lo_th   = lo_diff[8] ? 8'h00 : lo_diff[7:0];

    // Folded values include the current sample so a sample landing on the
    // closing cycle still belongs to the window being published.
    max_fold = (smp_v_q && (smp_q > cur_max_q)) ? smp_q : cur_max_q;
    min_fold = (smp_v_q && (smp_q < cur_min_q)) ? smp_q : cur_min_q;
    rise     = smp_v_q && (state_q == ST_LOW)  && (smp_q >= hi_th);
    fall     = smp_v_q && (state_q == ST_HIGH) && (smp_q <= lo_th);
    edge_fold = (rise && (edge_cnt_q != 32'hFFFF_FFFF)) ? edge_cnt_q + 32'd1 : edge_cnt_q;
    mid_sum  = {1'b0, max_fold} + {1'b0, min_fold};

    state_d = state_q;
    if (rise) begin
      state_d = ST_HIGH;
    end else if (fall) begin
      state_d = ST_LOW;
    end

    freq_d       = freq_q;
    vmax_d       = vmax_q;
    vmin_d       = vmin_q;
    vpp_d        = vpp_q;
    mid_d        = mid_q;
    meas_valid_d = gate_end;
    cur_max_d    = max_fold;
    cur_min_d    = min_fold;
    edge_cnt_d   = edge_fold;
    if (gate_end) begin
      freq_d     = edge_fold;
      vmax_d     = max_fold;
      vmin_d     = min_fold;
      vpp_d      = max_fold - min_fold;
      mid_d      = 8'(mid_sum >> 1);
      cur_max_d  = 8'h00;
      cur_min_d  = 8'hFF;
      edge_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_cnt_q    <= 32'd0;
      ad_clk_q     <= 1'b0;
      smp_q        <= 8'h00;
      smp_v_q      <= 1'b0;
      gate_cnt_q   <= 32'd0;
      cur_max_q    <= 8'h00;
      cur_min_q    <= 8'hFF;
      edge_cnt_q   <= 32'd0;
      state_q      <= ST_LOW;
      mid_q        <= 8'd128;
      freq_q       <= 32'd0;
      vmax_q       <= 8'h00;
      vmin_q       <= 8'h00;
      vpp_q        <= 8'h00;
      meas_valid_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      ad_clk_q     <= ad_clk_d;
      smp_q        <= smp_d;
      smp_v_q      <= smp_v_d;
      gate_cnt_q   <= gate_cnt_d;
      cur_max_q    <= cur_max_d;
      cur_min_q    <= cur_min_d;
      edge_cnt_q   <= edge_cnt_d;
      state_q      <= state_d;
      mid_q        <= mid_d;
      freq_q       <= freq_d;
      vmax_q       <= vmax_d;
      vmin_q       <= vmin_d;
      vpp_q        <= vpp_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign ad_clk     = ad_clk_q;
  assign freq       = freq_q;
  assign vmax       = vmax_q;
  assign vmin       = vmin_q;
  assign vpp        = vpp_q;
  assign meas_valid = meas_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_wave_meter.sv
`default_nettype none
// ============================================================================
// tb_adc_wave_meter : window-aligned stimulus with a per-window result scoreboard
// Revision 1.0
// ============================================================================
module tb_adc_wave_meter;

  localparam int GATE   = 1000;
  localparam int GATE_B = 1001;
  localparam int M_CONST = 0, M_SQ = 1, M_STEP = 2, M_NOISE = 3, M_SMALL = 4;

  typedef struct {
    int          mode;
    bit          chk;
    bit          amp;
    logic [31:0] freq;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
    logic [7:0]  vpp;
  } rec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  ad_data = 8'd128;
  logic [7:0]  ad_data_b = 8'd100;
  logic        ad_clk, meas_valid, ad_clk_b, meas_valid_b;
  logic [31:0] freq, freq_b;
  logic [7:0]  vmax, vmin, vpp, vmax_b, vmin_b, vpp_b;

  int   checks = 0;
  int   failures = 0;
  int   k = 0;
  int   nb = 0;
  int   mode = M_CONST;
  rec_t tab [13];
  rec_t sb [$];

  always #5 sys_clk = ~sys_clk;

  adc_wave_meter #(.CLK_DIV(2), .GATE_CYC(GATE), .HYST(8)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_data(ad_data), .ad_clk(ad_clk),
    .freq(freq), .vmax(vmax), .vmin(vmin), .vpp(vpp), .meas_valid(meas_valid)
  );

  adc_wave_meter #(.CLK_DIV(2), .GATE_CYC(GATE_B), .HYST(8)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_data(ad_data_b), .ad_clk(ad_clk_b),
    .freq(freq_b), .vmax(vmax_b), .vmin(vmin_b), .vpp(vpp_b), .meas_valid(meas_valid_b)
  );

  // Cycle index since reset release; inputs for cycle k are driven at its negedge.
  always @(posedge sys_clk) begin
    if (sys_rst) k <= 0;
    else         k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, k);
    end
  endtask

  function automatic logic [7:0] wave(input int m, input int kk);
    int v;
    case (m)
      M_SQ:    v = ((kk % 200) < 100) ? 0 : 255;
      M_STEP: begin
        case ((kk % 40) / 10)
          0:       v = 64;
          1:       v = 128;
          2:       v = 192;
          default: v = 128;
        endcase
      end
      M_NOISE: v = (((kk % 100) < 50) ? 100 : 160) + int'($urandom_range(12)) - 6;
      M_SMALL: v = ((kk % 100) < 50) ? 124 : 132;
      default: v = 128;
    endcase
    return 8'(v);
  endfunction

  task automatic drive_cycle();
    ad_data   = wave(mode, k);
    ad_data_b = (k == 999) ? 8'd255 : 8'd100;
    @(negedge sys_clk);
  endtask

  always @(negedge sys_clk) begin
    rec_t e;
    if (!sys_rst && k < 40)
      check("ad_clk_phase", {31'd0, ad_clk}, 32'((k / 2) % 2));
    if (meas_valid) begin
      check("meas_valid_period", 32'(k % GATE), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas_valid actual=pulse required=none (cycle %0d)", k);
      end else begin
        e = sb.pop_front();
        if (e.chk) begin
          check("freq", freq, e.freq);
          if (e.amp) begin
            check("vmax", {24'd0, vmax}, {24'd0, e.vmax});
            check("vmin", {24'd0, vmin}, {24'd0, e.vmin});
            check("vpp",  {24'd0, vpp},  {24'd0, e.vpp});
          end
        end
      end
    end
    if (meas_valid_b) begin
      check("b_period", 32'(k % GATE_B), 32'd0);
      if (nb == 0) begin
        check("b_boundary_freq", freq_b, 32'd1);
        check("b_boundary_vmax", {24'd0, vmax_b}, 32'd255);
        check("b_boundary_vmin", {24'd0, vmin_b}, 32'd100);
        check("b_boundary_vpp",  {24'd0, vpp_b},  32'd155);
      end else if (nb == 1) begin
        check("b_next_freq", freq_b, 32'd0);
        check("b_next_vmax", {24'd0, vmax_b}, 32'd100);
        check("b_next_vpp",  {24'd0, vpp_b},  32'd0);
      end
      nb++;
    end
  end

  initial begin
    tab[0]  = '{M_CONST, 1'b1, 1'b1, 32'd0,  8'd128, 8'd128, 8'd0};
    tab[1]  = '{M_CONST, 1'b1, 1'b1, 32'd0,  8'd128, 8'd128, 8'd0};
    tab[2]  = '{M_SQ,    1'b0, 1'b0, 32'd0,  8'd0,   8'd0,   8'd0};
    tab[3]  = '{M_SQ,    1'b1, 1'b1, 32'd5,  8'd255, 8'd0,   8'd255};
    tab[4]  = '{M_SQ,    1'b1, 1'b1, 32'd5,  8'd255, 8'd0,   8'd255};
    tab[5]  = '{M_STEP,  1'b0, 1'b0, 32'd0,  8'd0,   8'd0,   8'd0};
    tab[6]  = '{M_STEP,  1'b1, 1'b1, 32'd25, 8'd192, 8'd64,  8'd128};
    tab[7]  = '{M_STEP,  1'b1, 1'b1, 32'd25, 8'd192, 8'd64,  8'd128};
    tab[8]  = '{M_NOISE, 1'b0, 1'b0, 32'd0,  8'd0,   8'd0,   8'd0};
    tab[9]  = '{M_NOISE, 1'b1, 1'b0, 32'd10, 8'd0,   8'd0,   8'd0};
    tab[10] = '{M_SMALL, 1'b0, 1'b0, 32'd0,  8'd0,   8'd0,   8'd0};
    tab[11] = '{M_SMALL, 1'b1, 1'b1, 32'd0,  8'd132, 8'd124, 8'd8};
    tab[12] = '{M_SMALL, 1'b1, 1'b1, 32'd0,  8'd132, 8'd124, 8'd8};

    sys_rst = 1'b1;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_freq", freq, 32'd0);
    check("rst_vmax", {24'd0, vmax}, 32'd0);
    check("rst_meas_valid", {31'd0, meas_valid}, 32'd0);
    check("rst_ad_clk", {31'd0, ad_clk}, 32'd0);
    sys_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      mode = tab[i].mode;
      sb.push_back(tab[i]);
      repeat (GATE) drive_cycle();
    end

    // Abort a window halfway through with a 3-cycle reset.
    mode = M_CONST;
    repeat (GATE / 2) drive_cycle();
    sys_rst = 1'b1;
    repeat (3) drive_cycle();
    check("midrst_freq", freq, 32'd0);
    check("midrst_vmax", {24'd0, vmax}, 32'd0);
    check("midrst_vmin", {24'd0, vmin}, 32'd0);
    check("midrst_vpp",  {24'd0, vpp},  32'd0);
    check("midrst_meas_valid", {31'd0, meas_valid}, 32'd0);
    check("midrst_ad_clk", {31'd0, ad_clk}, 32'd0);
    sys_rst = 1'b0;
    sb.push_back(tab[0]);
    repeat (GATE + 10) drive_cycle();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("b_pulses_seen", {31'd0, nb >= 2}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
